// File: rtl/mdu_pkg.sv
// Shared types and decode helpers for the iterative RV32M multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } mdu_state_e;

  typedef enum logic {
    ENG_MUL = 1'b0,
    ENG_DIV = 1'b1
  } engine_mode_e;

  function automatic logic is_div(mdu_op_e op);
    return op[2];
  endfunction

  function automatic logic a_signed(mdu_op_e op);
    return op inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
  endfunction

  function automatic logic b_signed(mdu_op_e op);
    return op inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM};
  endfunction

endpackage

// File: rtl/mdu_shift_engine.sv
// Radix-2 unsigned engine: shift-add multiply or restoring shift-subtract divide,
// one step per enabled edge, on a 2W-bit accumulator {high, low}.
module mdu_shift_engine
  import mdu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           clear,
  input  logic           load,
  input  logic           step,
  input  engine_mode_e   load_mode,
  input  logic [W-1:0]   load_a,
  input  logic [W-1:0]   load_b,
  output logic [2*W-1:0] acc_next,
  output logic           last
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

  logic [2*W-1:0] acc;
  logic [W-1:0]   operand;
  engine_mode_e   mode;
  logic [CW-1:0]  count;

  logic [W:0] mul_sum;
  logic [W:0] div_shift;
  logic [W:0] div_diff;

  // Multiply: high half accumulates, low half holds the multiplier shifting out.
  // Divide: high half is the partial remainder, low half the dividend becoming quotient.
  // NOTE: every signal written in always_comb is assigned first so no latch is inferred.
  always_comb begin
    mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, operand} : '0);
    div_shift = acc[2*W-1:W-1];
    div_diff  = div_shift - {1'b0, operand};
    acc_next  = {mul_sum, acc[W-1:1]};
    if (mode == ENG_DIV) begin
      if (div_diff[W]) acc_next = {div_shift[W-1:0], acc[W-2:0], 1'b0};
      else             acc_next = {div_diff[W-1:0],  acc[W-2:0], 1'b1};
    end
  end

  assign last = (count == LAST_STEP);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc     <= '0;
      operand <= '0;
      mode    <= ENG_MUL;
      count   <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      acc     <= {{W{1'b0}}, load_a};
      operand <= load_b;
      mode    <= load_mode;
      count   <= '0;
    end else if (step) begin
      acc   <= acc_next;
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit with valid/ready handshakes, tag passthrough,
// flush abort and single-cycle fast paths for divide-by-zero and signed overflow.
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_op,
  input  logic [DATA_WIDTH-1:0] in_src_a,
  input  logic [DATA_WIDTH-1:0] in_src_b,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  localparam int W = DATA_WIDTH;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  mdu_state_e           state;
  mdu_op_e              op_in;
  mdu_op_e              op_q;
  logic                 neg_res_q;
  logic                 neg_rem_q;
  logic [TAG_WIDTH-1:0] tag_q;

  logic         accept;
  logic         a_neg, b_neg;
  logic [W-1:0] a_mag, b_mag;
  logic         div_zero, div_ovf, fast;
  logic [W-1:0] fast_result;

  logic [2*W-1:0] eng_acc_next;
  logic           eng_last;
  logic [2*W-1:0] prod;
  logic [W-1:0]   quo, rem, final_result;

  assign op_in    = mdu_op_e'(in_op);
  assign in_ready = (state == ST_IDLE) && !flush;
  assign accept   = in_valid && in_ready;

  // Pre-processing: operand magnitudes, sign flags and fast-path detection.
  always_comb begin
    a_neg    = a_signed(op_in) && in_src_a[W-1];
    b_neg    = b_signed(op_in) && in_src_b[W-1];
    a_mag    = a_neg ? (~in_src_a + 1'b1) : in_src_a;
    b_mag    = b_neg ? (~in_src_b + 1'b1) : in_src_b;
    div_zero = is_div(op_in) && (in_src_b == '0);
    div_ovf  = (op_in == MDU_DIV || op_in == MDU_REM) &&
               (in_src_a == MIN_NEG) && (in_src_b == '1);
    fast     = div_zero || div_ovf;
    if (div_zero) fast_result = (op_in == MDU_DIV || op_in == MDU_DIVU) ? '1 : in_src_a;
    else if (op_in == MDU_DIV) fast_result = MIN_NEG;
    else fast_result = '0;
  end

  mdu_shift_engine #(.W(W)) u_engine (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (flush),
    .load      (accept),
    .step      (state == ST_BUSY),
    .load_mode (is_div(op_in) ? ENG_DIV : ENG_MUL),
    .load_a    (a_mag),
    .load_b    (b_mag),
    .acc_next  (eng_acc_next),
    .last      (eng_last)
  );

  // Sign correction applied to the engine's final step value.
  always_comb begin
    prod = neg_res_q ? -eng_acc_next : eng_acc_next;
    quo  = neg_res_q ? -eng_acc_next[W-1:0] : eng_acc_next[W-1:0];
    rem  = neg_rem_q ? -eng_acc_next[2*W-1:W] : eng_acc_next[2*W-1:W];
    case (op_q)
      MDU_MUL:                        final_result = prod[W-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: final_result = prod[2*W-1:W];
      MDU_DIV, MDU_DIVU:              final_result = quo;
      default:                        final_result = rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      op_q       <= MDU_MUL;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      tag_q      <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (flush) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_q      <= op_in;
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            tag_q     <= in_tag;
            if (fast) begin
              state      <= ST_DONE;
              out_valid  <= 1'b1;
              out_result <= fast_result;
              out_tag    <= in_tag;
            end else begin
              state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (eng_last) begin
            state      <= ST_DONE;
            out_valid  <= 1'b1;
            out_result <= final_result;
            out_tag    <= tag_q;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
